// File: rtl/nanov_spi_pkg.sv
// Shared types and constants for the nanoV SPI memory controller.
// The optional continuation mode is selected with SPI_MEM_CONTINUE_EN.
package nanov_spi_pkg;

  localparam int unsigned ADDR_BITS_DEF = 24;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE,
    HOLD
  } state_t;

  function automatic logic [7:0] spi_cmd(input logic write);
    return write ? SPI_CMD_WRITE : SPI_CMD_READ;
  endfunction

endpackage

// File: rtl/nanov_spi_shifter.sv
// Serial engine: two clk cycles per bit, MSB-first out of tx, miso shifted into rx at LSB.
// A load may coincide with the final edge of the previous segment so segments run back to back.
module nanov_spi_shifter
  import nanov_spi_pkg::*;
#(
  parameter int unsigned SW = 32,
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [SW-1:0] load_data,
  input  logic [CW-1:0] load_last,
  input  logic          miso,
  output logic          sclk,
  output logic          mosi,
  output logic [SW-1:0] rx,
  output logic          finished,
  output logic          last_c
);

  logic [SW-1:0] tx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last_idx;
  logic          active;

  assign mosi   = tx[SW-1];
  assign last_c = active & sclk & (cnt == last_idx);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx       <= '0;
      rx       <= '0;
      cnt      <= '0;
      last_idx <= '0;
      active   <= 1'b0;
      sclk     <= 1'b0;
      finished <= 1'b0;
    end else begin
      finished <= 1'b0;
      // miso is captured on the edge that ends the high phase, even when a new segment loads
      if (active && sclk) rx <= {rx[SW-2:0], miso};
      if (load) begin
        tx       <= load_data;
        cnt      <= '0;
        last_idx <= load_last;
        sclk     <= 1'b0;
        active   <= 1'b1;
      end else if (active) begin
        if (!sclk) begin
          sclk <= 1'b1;
        end else begin
          sclk <= 1'b0;
          tx   <= {tx[SW-2:0], 1'b0};
          cnt  <= cnt + CW'(1);
          if (cnt == last_idx) begin
            active   <= 1'b0;
            finished <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/nanov_spi_mem_ctrl.sv
// SPI master turning single-word nanoV memory requests into serial-RAM READ/WRITE transactions.
// Define SPI_MEM_CONTINUE_EN to keep the chip selected and stream sequential same-direction requests.
module nanov_spi_mem_ctrl
  import nanov_spi_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned ADDR_BITS  = ADDR_BITS_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic                    is_write,
  input  logic [ADDR_BITS-1:0]    addr,
  input  logic [8*DATA_BYTES-1:0] wdata,
  output logic                    busy,
  output logic                    done,
  output logic [8*DATA_BYTES-1:0] rdata,
  output logic                    spi_select,
  output logic                    spi_clk_out,
  output logic                    spi_mosi,
  input  logic                    spi_miso
);

  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int unsigned SW = (ADDR_BITS > DW) ? ADDR_BITS : DW;
  localparam int unsigned CW = $clog2(SW);

  state_t               state;
  logic                 write_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [DW-1:0]        wdata_q;
  logic                 relaunch;

  logic                 load_c;
  logic [SW-1:0]        load_data_c;
  logic [CW-1:0]        load_last_c;
  logic [SW-1:0]        rx;
  logic                 finished;
  logic                 last_c;

  // Little-endian on the wire: byte 0 travels first, so it sits at the top of the shift word
  function automatic logic [DW-1:0] byte_swap(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < int'(DATA_BYTES); i++) begin
      r[8*i +: 8] = v[8*(int'(DATA_BYTES)-1-i) +: 8];
    end
    return r;
  endfunction

`ifdef SPI_MEM_CONTINUE_EN
  logic cont_c;
  assign cont_c = (is_write == write_q) && (addr == addr_q + ADDR_BITS'(DATA_BYTES));
`endif

  // Shifter load strobes: fire on the edge that enters each segment
  always_comb begin
    load_c      = 1'b0;
    load_data_c = '0;
    load_last_c = '0;
    case (state)
      IDLE: begin
        if (relaunch || start) begin
          load_c      = 1'b1;
          load_data_c = SW'(spi_cmd(relaunch ? write_q : is_write)) << (SW - 8);
          load_last_c = CW'(7);
        end
      end
      CMD: begin
        if (last_c) begin
          load_c      = 1'b1;
          load_data_c = SW'(addr_q) << (SW - ADDR_BITS);
          load_last_c = CW'(ADDR_BITS - 1);
        end
      end
      ADDR: begin
        if (last_c) begin
          load_c      = 1'b1;
          load_data_c = write_q ? (SW'(byte_swap(wdata_q)) << (SW - DW)) : '0;
          load_last_c = CW'(DW - 1);
        end
      end
`ifdef SPI_MEM_CONTINUE_EN
      HOLD: begin
        if (start && cont_c) begin
          load_c      = 1'b1;
          load_data_c = is_write ? (SW'(byte_swap(wdata)) << (SW - DW)) : '0;
          load_last_c = CW'(DW - 1);
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= '0;
      spi_select <= 1'b1;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      relaunch   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (relaunch) begin
            relaunch   <= 1'b0;
            spi_select <= 1'b0;
            state      <= CMD;
          end else if (start) begin
            write_q    <= is_write;
            addr_q     <= addr;
            wdata_q    <= wdata;
            busy       <= 1'b1;
            spi_select <= 1'b0;
            state      <= CMD;
          end
        end
        CMD:  if (last_c) state <= ADDR;
        ADDR: if (last_c) state <= DATA;
        DATA: begin
          // finished arrives one cycle after the last miso sample, so rx is complete here
          if (finished) begin
            state <= DONE;
            done  <= 1'b1;
            if (!write_q) rdata <= byte_swap(rx[DW-1:0]);
`ifndef SPI_MEM_CONTINUE_EN
            spi_select <= 1'b1;
`endif
          end
        end
        DONE: begin
          busy <= 1'b0;
`ifdef SPI_MEM_CONTINUE_EN
          state <= HOLD;
`else
          state <= IDLE;
`endif
        end
`ifdef SPI_MEM_CONTINUE_EN
        HOLD: begin
          if (start) begin
            write_q <= is_write;
            addr_q  <= addr;
            wdata_q <= wdata;
            busy    <= 1'b1;
            if (cont_c) begin
              state <= DATA;
            end else begin
              spi_select <= 1'b1;
              relaunch   <= 1'b1;
              state      <= IDLE;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  nanov_spi_shifter #(
    .SW(SW),
    .CW(CW)
  ) u_shifter (
    .clk      (clk),
    .rstn     (rstn),
    .load     (load_c),
    .load_data(load_data_c),
    .load_last(load_last_c),
    .miso     (spi_miso),
    .sclk     (spi_clk_out),
    .mosi     (spi_mosi),
    .rx       (rx),
    .finished (finished),
    .last_c   (last_c)
  );

endmodule

// File: doc/nanov_spi_mem_ctrl.md
Name: nanov_spi_mem_ctrl

Overview:
- SPI master that turns single-word memory requests from the nanoV core into serial-RAM READ (0x03) and WRITE (0x02) transactions.
- Sits between the core's load/store/fetch path and the off-chip SPI RAM pins (spi_select, spi_clk_out, spi_mosi, spi_miso).
- Handles one request at a time: command, 24-bit address, then DATA_BYTES data bytes.

Parameters:
- DATA_BYTES, 4: bytes transferred per request (1, 2 or 4).
- ADDR_BITS, 24: address width, shifted MSB-first.

Ports:
- clk  in  1  core clock
- rstn  in  1  reset, synchronous, active-low
- start  in  1  request strobe; sampled only while busy=0
- is_write  in  1  1=WRITE 0x02, 0=READ 0x03; sampled with start
- addr  in  ADDR_BITS  byte address; sampled with start
- wdata  in  8*DATA_BYTES  write data; sampled with start
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at end of transaction
- rdata  out  8*DATA_BYTES  read data; valid from done until the next start
- spi_select  out  1  chip select, active-low
- spi_clk_out  out  1  SPI clock, mode 0
- spi_mosi  out  1  serial out
- spi_miso  in  1  serial in

Behaviour:
- Reset (rstn=0 at a clk edge) forces: spi_select=1, spi_clk_out=0, spi_mosi=0, busy=0, done=0, rdata=0, state IDLE.
- Reset applied mid-transaction aborts at that edge. No completion pulse; a partial write in the RAM is acceptable.
- States:
  - IDLE: start=1 latches is_write/addr/wdata, sets busy=1, spi_select=0 and goes to CMD.
  - CMD: 8 bits.
  - ADDR: ADDR_BITS bits.
  - DATA: 8*DATA_BYTES bits.
  - DONE: one cycle, then back to IDLE.
- Bit timing: each bit takes 2 clk cycles.
  - Phase 0: spi_clk_out=0 and spi_mosi holds the current bit.
  - Phase 1: spi_clk_out=1; spi_miso is sampled on the clk edge that ends phase 1.
- Shift order: command and address MSB-first.
- Data byte order is little-endian:
  - Byte 0 (bits 7:0) goes on the wire first, and the first byte received lands in rdata[7:0].
  - Within each byte, MSB first.
- In DATA during a read, spi_mosi=0.
- DONE:
  - spi_select=1, spi_clk_out=0, done=1, busy=1.
  - rdata is updated at entry to DONE for reads only; writes leave rdata unchanged.
- Next cycle: IDLE with busy=0. The earliest new start is sampled then, which guarantees at least 1 cycle of deselect.
- Latency: start-sampling edge to done high = 2*(8+ADDR_BITS+8*DATA_BYTES)+1 cycles. This is 129 for the defaults.
- start while busy=1 is ignored; no queuing.
- Address wrap: the RAM handles wrap. The controller never increments addr except as described under Optional Feature.

Optional Feature:
- Macro: SPI_MEM_CONTINUE_EN.
- Enabled:
  - After DONE, spi_select stays low (state HOLD, busy=0, spi_clk_out=0).
  - A new start with the same is_write and addr == last_addr+DATA_BYTES (mod 2^ADDR_BITS) skips CMD/ADDR and enters DATA directly. Latency is then 2*8*DATA_BYTES+1 = 65 cycles.
  - Any other start raises spi_select for one cycle (done=0, busy=1), then runs the full sequence.
  - Latency for such a non-continuing start is 2*(8+ADDR_BITS+8*DATA_BYTES)+2 = 130 cycles.
- Disabled: HOLD does not exist; behaviour is exactly as above.

Decomposition:
- Package nanov_spi_pkg holds:
  - state enum (IDLE, CMD, ADDR, DATA, DONE, HOLD)
  - SPI_CMD_READ=8'h03, SPI_CMD_WRITE=8'h02
  - ADDR_BITS default
- One natural sub-module: nanov_spi_shifter. It is a bit counter plus shift register, and generates the phase toggle, mosi/miso shifting and a bit-count-reached flag.
- The top holds the FSM.

Test Plan:
- Read: preload RAM 0x000100 = bytes 78 56 34 12; start read addr=0x000100.
  - Mosi shows 0x03, 0x000100.
  - done exactly 129 cycles after start, rdata=0x12345678.
- Write then read: write wdata=0xDEADBEEF to 0x0000F0, then read 0x0000F0.
  - RAM bytes EF BE AD DE.
  - rdata=0xDEADBEEF; rdata unchanged across the write's done.
- start pulsed while busy at cycle 40: ignored.
  - Single transaction, one done pulse.
  - spi_select high exactly 1 cycle between back-to-back requests.
- Reset asserted at cycle 70 of a read:
  - Next edge spi_select=1, busy=0, done=0, rdata=0.
  - A following read of 0x000100 completes normally.
- With SPI_MEM_CONTINUE_EN: reads at 0x000100 then 0x000104.
  - Second read has no command/address bits, done after 65 cycles, spi_select never rises.
  - A third read at 0x000200 raises spi_select for 1 cycle and completes after 130 cycles.
